// File: rtl/snes_pad_responder_if.sv
// Signal bundle between an SNES console-side initiator and the pad responder.
// The initiator (master) drives latch, shift clock and the button levels;
// the responder (slave) returns the serial button stream and its status flags.
interface snes_pad_responder_if;
  logic        data_latch;
  logic        snes_clk;
  logic [11:0] buttons;
  logic        serial_data;
  logic        busy;
  logic        frame_done;

  modport master (
    output data_latch,
    output snes_clk,
    output buttons,
    input  serial_data,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  data_latch,
    input  snes_clk,
    input  buttons,
    output serial_data,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/snes_pad_responder.sv
// SNES controller emulation: answers the console's latch / shift-clock
// protocol with a 16-bit active-low button frame. Latch and shift clock are
// asynchronous to clk and are synchronized before any edge is acted on.
module snes_pad_responder (
  input  logic                 clk,
  input  logic                 reset,
  snes_pad_responder_if.slave  pad
);

  localparam int FRAME_W = 16;
  localparam int BTN_W   = 12;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  // Synchronizer stages: p0/p1 resolve metastability, p2 is edge history
  logic latch_p0, latch_p1, latch_p2;
  logic sclk_p0, sclk_p1, sclk_p2;
  logic [BTN_W-1:0] btn_p0, btn_p1;

  logic latch_rise, latch_fall, sclk_rise;

  state_t               state, state_d;
  logic [FRAME_W-1:0]   shreg, shreg_d;
  logic [4:0]           bit_cnt, bit_cnt_d;
  logic                 serial_q, serial_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Frame as the console expects it: pressed buttons read as 0, and the four
  // trailing ID bits read as 1 (standard pad signature).
  function automatic logic [FRAME_W-1:0] frame_value(input logic [BTN_W-1:0] b);
    return {4'b1111, ~b};
  endfunction

  // Latch and shift-clock synchronizers; shift clock idles high after reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      latch_p0 <= 1'b0;
      latch_p1 <= 1'b0;
      latch_p2 <= 1'b0;
      sclk_p0  <= 1'b1;
      sclk_p1  <= 1'b1;
      sclk_p2  <= 1'b1;
    end else begin
      latch_p0 <= pad.data_latch;
      latch_p1 <= latch_p0;
      latch_p2 <= latch_p1;
      sclk_p0  <= pad.snes_clk;
      sclk_p1  <= sclk_p0;
      sclk_p2  <= sclk_p1;
    end
  end

  // Button synchronizer, aligned with the latch path so loads see matching latency
  always_ff @(posedge clk) begin
    btn_p0 <= pad.buttons;
    btn_p1 <= btn_p0;
  end

  // Edge detect: compare synchronized value against its history flop
  assign latch_rise = latch_p1 & ~latch_p2;
  assign latch_fall = ~latch_p1 & latch_p2;
  assign sclk_rise  = sclk_p1 & ~sclk_p2;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      shreg    <= {FRAME_W{1'b1}};
      bit_cnt  <= 5'd0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_d;
      shreg    <= shreg_d;
      bit_cnt  <= bit_cnt_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic; a latch rise beats everything, including a shift edge
  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    bit_cnt_d = bit_cnt;
    done_d    = 1'b0;

    if (latch_rise) begin
      state_d   = LOAD;
      shreg_d   = frame_value(btn_p1);
      bit_cnt_d = 5'd0;
    end else begin
      case (state)
        IDLE: ;
        LOAD: begin
          if (latch_fall) begin
            state_d   = SHIFT;
            bit_cnt_d = 5'd0;
          end else if (latch_p1) begin
            shreg_d = frame_value(btn_p1);
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            shreg_d   = {1'b1, shreg[FRAME_W-1:1]};
            bit_cnt_d = bit_cnt + 5'd1;
            if (bit_cnt == 5'd15) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == LOAD) || (state_d == SHIFT);
    // DONE drives 0 so the console sees a connected pad on over-clocked reads
    if (busy_d) begin
      serial_d = shreg_d[0];
    end else begin
      serial_d = (state_d != DONE);
    end
  end

  assign pad.serial_data = serial_q;
  assign pad.busy        = busy_q;
  assign pad.frame_done  = done_q;

endmodule

// File: tb/tb_snes_pad_responder.sv
// Self-checking bench for snes_pad_responder: the expected serial stream is
// queued when a frame is latched and popped as each bit is read back.
`timescale 1ns/1ps
module tb_snes_pad_responder;

  localparam int HALF = 1000;   // snes_clk half period in ns

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  int   fd_total;
  int   fd_base;
  logic sb[$];

  snes_pad_responder_if pad_if ();

  snes_pad_responder dut (
    .clk   (clk),
    .reset (reset),
    .pad   (pad_if.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Running count of cycles with frame_done high
  always @(negedge clk) begin
    if (pad_if.frame_done === 1'b1) fd_total = fd_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic push_frame(input logic [11:0] b);
    for (int i = 0; i < 16; i++) sb.push_back((i < 12) ? ~b[i] : 1'b1);
  endtask

  task automatic sample_bit(input string tag);
    logic e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check(tag, {31'd0, pad_if.serial_data}, {31'd0, e});
    end
  endtask

  task automatic shift_bit(input string tag);
    pad_if.snes_clk = 1'b0;
    #HALF;
    sample_bit(tag);
    pad_if.snes_clk = 1'b1;
    #HALF;
  endtask

  task automatic latch_pulse(input int dur);
    pad_if.data_latch = 1'b1;
    #dur;
    pad_if.data_latch = 1'b0;
    #HALF;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    fd_total = 0;
    reset    = 1'b0;
    pad_if.data_latch = 1'b0;
    pad_if.snes_clk   = 1'b1;
    pad_if.buttons    = 12'h000;

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    check("rst_serial", {31'd0, pad_if.serial_data}, 32'd1);
    check("rst_busy",   {31'd0, pad_if.busy},        32'd0);
    check("rst_done",   {31'd0, pad_if.frame_done},  32'd0);
    check("rst_state",  32'(dut.state),              32'd0);
    reset = 1'b1;
    #HALF;
    check("idle_serial", {31'd0, pad_if.serial_data}, 32'd1);

    // Nominal frame: B and A pressed, 12 us latch
    fd_base = fd_total;
    pad_if.buttons = 12'h101;
    pad_if.data_latch = 1'b1;
    #6000;
    check("nom_load_busy",   {31'd0, pad_if.busy},        32'd1);
    check("nom_load_serial", {31'd0, pad_if.serial_data}, 32'd0);
    #6000;
    pad_if.data_latch = 1'b0;
    #HALF;
    push_frame(12'h101);
    for (int i = 0; i < 16; i++) shift_bit($sformatf("nom_bit%0d", i));
    #200;
    check("nom_done_serial", {31'd0, pad_if.serial_data}, 32'd0);
    check("nom_done_busy",   {31'd0, pad_if.busy},        32'd0);
    check("nom_fd_count",    fd_total - fd_base,          32'd1);

    // Load tracking: button change during latch shows up three clk edges later
    fd_base = fd_total;
    pad_if.buttons = 12'h000;
    pad_if.data_latch = 1'b1;
    #HALF;
    check("trk_before", {31'd0, pad_if.serial_data}, 32'd1);
    @(posedge clk);
    #1 pad_if.buttons = 12'h001;
    @(posedge clk);
    #1 check("trk_edge1", {31'd0, pad_if.serial_data}, 32'd1);
    @(posedge clk);
    #1 check("trk_edge2", {31'd0, pad_if.serial_data}, 32'd1);
    @(posedge clk);
    #1 check("trk_edge3", {31'd0, pad_if.serial_data}, 32'd0);
    #HALF;
    pad_if.data_latch = 1'b0;
    #HALF;
    pad_if.buttons = 12'h000;
    #HALF;
    check("trk_frozen", {31'd0, pad_if.serial_data}, 32'd0);
    push_frame(12'h001);
    for (int i = 0; i < 16; i++) shift_bit($sformatf("trk_bit%0d", i));
    check("trk_fd_count", fd_total - fd_base, 32'd1);

    // Re-latch after 5 shifts aborts the frame
    fd_base = fd_total;
    pad_if.buttons = 12'hFFF;
    latch_pulse(2000);
    push_frame(12'hFFF);
    for (int i = 0; i < 5; i++) shift_bit($sformatf("rel_a_bit%0d", i));
    sb.delete();
    pad_if.data_latch = 1'b1;
    #HALF;
    check("rel_state",  32'(dut.state),              32'd1);
    check("rel_busy",   {31'd0, pad_if.busy},        32'd1);
    check("rel_serial", {31'd0, pad_if.serial_data}, 32'd0);
    check("rel_no_fd",  fd_total - fd_base,          32'd0);
    pad_if.data_latch = 1'b0;
    #HALF;
    push_frame(12'hFFF);
    for (int i = 0; i < 16; i++) shift_bit($sformatf("rel_b_bit%0d", i));
    check("rel_fd_count", fd_total - fd_base, 32'd1);

    // Overclocking: 20 pulses, trailing bits read 0, bit_count holds at 16
    fd_base = fd_total;
    pad_if.buttons = 12'h0A5;
    latch_pulse(2000);
    push_frame(12'h0A5);
    for (int i = 0; i < 4; i++) sb.push_back(1'b0);
    for (int i = 0; i < 20; i++) shift_bit($sformatf("ovr_bit%0d", i));
    check("ovr_bit_cnt",  32'(dut.bit_cnt),    32'd16);
    check("ovr_fd_count", fd_total - fd_base,  32'd1);

    // Reset in the middle of SHIFT
    fd_base = fd_total;
    pad_if.buttons = 12'h3C3;
    latch_pulse(2000);
    push_frame(12'h3C3);
    for (int i = 0; i < 8; i++) shift_bit($sformatf("rst_bit%0d", i));
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    check("mrst_serial", {31'd0, pad_if.serial_data}, 32'd1);
    check("mrst_busy",   {31'd0, pad_if.busy},        32'd0);
    for (int i = 0; i < 4; i++) sb.push_back(1'b1);
    for (int i = 0; i < 4; i++) shift_bit($sformatf("mrst_idle%0d", i));
    check("mrst_busy_after", {31'd0, pad_if.busy}, 32'd0);
    check("mrst_no_fd",      fd_total - fd_base,   32'd0);

    // Coincident latch and shift-clock rise while in SHIFT: latch wins
    fd_base = fd_total;
    pad_if.buttons = 12'h010;
    latch_pulse(2000);
    push_frame(12'h010);
    for (int i = 0; i < 3; i++) shift_bit($sformatf("coin_bit%0d", i));
    pad_if.buttons  = 12'h000;
    pad_if.snes_clk = 1'b0;
    #HALF;
    sample_bit("coin_bit3");
    sb.delete();
    pad_if.data_latch = 1'b1;
    pad_if.snes_clk   = 1'b1;
    #200;
    check("coin_state",   32'(dut.state),              32'd1);
    check("coin_bit_cnt", 32'(dut.bit_cnt),            32'd0);
    check("coin_serial",  {31'd0, pad_if.serial_data}, 32'd1);
    check("coin_no_fd",   fd_total - fd_base,          32'd0);
    #HALF;
    pad_if.data_latch = 1'b0;
    #HALF;
    push_frame(12'h000);
    for (int i = 0; i < 16; i++) shift_bit($sformatf("coin_b_bit%0d", i));
    check("coin_fd_count", fd_total - fd_base, 32'd1);
    check("coin_sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
